// File: rtl/tick_prescaler.sv
// Programmable tick prescaler: divides clk down to a one-cycle tick, with a fast mode and a half-period square wave.
// Optional signed period trim register is built in when the macro TICK_TRIM_EN is defined.
module tick_prescaler #(
  parameter int CLK_HZ   = 48000000,
  parameter int TICK_HZ  = 1,
  parameter int CNT_W    = 26,
  parameter int FAST_DIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             fast,
`ifdef TICK_TRIM_EN
  input  logic             trim_wr,
  input  logic signed [7:0] trim_val,
`endif
  output logic             tick,
  output logic             half,
  output logic [CNT_W-1:0] count,
  output logic [15:0]      ticks
);

  localparam int PERIOD  = CLK_HZ / TICK_HZ;
  localparam int FPERIOD = (FAST_DIV < 1) ? 0 : PERIOD / FAST_DIV;
  // Two extra bits so a negatively trimmed terminal and the count compare as signed values.
  localparam int TW      = CNT_W + 2;

  typedef logic signed [TW-1:0] term_t;

  localparam term_t TERM_FAST = term_t'(FPERIOD - 1);
  localparam term_t TERM_NORM = term_t'(PERIOD - 1);
  localparam term_t ONE       = term_t'(1);
  localparam term_t TWO       = term_t'(2);

  generate
    if ((longint'(PERIOD) + 127) >= (longint'(1) << CNT_W)) begin : g_bad_width
      $error("tick_prescaler: CNT_W too narrow for PERIOD plus maximum trim");
    end
    if (FAST_DIV < 1) begin : g_bad_div
      $error("tick_prescaler: FAST_DIV must be at least 1");
    end
    if (FPERIOD < 2) begin : g_bad_fperiod
      $error("tick_prescaler: fast period must be at least 2 cycles");
    end
  endgenerate

  logic signed [7:0] trim;

`ifdef TICK_TRIM_EN
  // NOTE: every register, including the trim value, gets an explicit async reset value so
  // nothing depends on power-up contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trim <= '0;
    end else if (trim_wr) begin
      trim <= trim_val;
    end
  end
`else
  assign trim = '0;
`endif

  term_t term;
  term_t count_s;
  term_t half_thr;

  // NOTE: combinational outputs get a default at the top of the block so no path infers a latch.
  always_comb begin
    term     = TERM_NORM;
    count_s  = term_t'({2'b00, count});
    half_thr = '0;
    tick     = 1'b0;
    half     = 1'b0;

    if (fast) begin
      term = TERM_FAST;
    end else begin
      term = TERM_NORM + term_t'(trim);
    end

    half_thr = (term + ONE) / TWO;
    // >= rather than == lets a shortened period (fast mode, trim) terminate a count already past it.
    tick     = en & ~clr & (count_s >= term);
    half     = (count_s < half_thr);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  // clr never coincides with tick, so the tick total needs no separate clear term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ticks <= '0;
    end else if (tick) begin
      ticks <= ticks + 16'd1;
    end
  end

endmodule

// File: tb/tb_tick_prescaler.sv
// Self-checking bench for tick_prescaler: directed scenarios plus randomized stimulus against a cycle model.
// Trim scenarios run only when TICK_TRIM_EN is defined.
module tb_tick_prescaler;

  localparam int CLK_HZ   = 20;
  localparam int TICK_HZ  = 1;
  localparam int FAST_DIV = 4;
  localparam int CNT_W    = 8;
  localparam int PERIOD   = 20;
  localparam int FPERIOD  = 5;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             en    = 1'b0;
  logic             clr   = 1'b0;
  logic             fast  = 1'b0;
`ifdef TICK_TRIM_EN
  logic             trim_wr  = 1'b0;
  logic [7:0]       trim_val = 8'd0;
`endif
  logic             tick;
  logic             half;
  logic [CNT_W-1:0] count;
  logic [15:0]      ticks;

  int errors = 0;
  int checks = 0;

  // Reference state: the count within the period, the wrapped tick total and the current trim.
  int m_count = 0;
  int m_ticks = 0;
  int m_trim  = 0;
  int cycle   = 0;
  int tick_cycles[$];

  always #5 clk = ~clk;

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .CNT_W   (CNT_W),
    .FAST_DIV(FAST_DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .fast    (fast),
`ifdef TICK_TRIM_EN
    .trim_wr (trim_wr),
    .trim_val(trim_val),
`endif
    .tick    (tick),
    .half    (half),
    .count   (count),
    .ticks   (ticks)
  );

  function automatic int m_term();
    return fast ? (FPERIOD - 1) : (PERIOD - 1 + m_trim);
  endfunction

  function automatic logic m_tick();
    return en && !clr && (m_count >= m_term());
  endfunction

  function automatic logic m_half();
    return m_count < ((m_term() + 1) / 2);
  endfunction

  function automatic int nth_tick(int n);
    return (tick_cycles.size() > n) ? tick_cycles[n] : -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_ticks = 0;
    m_trim  = 0;
  endtask

  // One clock cycle: compare outputs mid-cycle, take the edge, advance the model, return at negedge.
  task automatic cyc();
    logic t;
    cycle++;
    #1;
    t = m_tick();
    check("tick",  tick,  t);
    check("half",  half,  m_half());
    check("count", count, m_count);
    check("ticks", ticks, m_ticks);
    if (tick === 1'b1) tick_cycles.push_back(cycle);
    @(posedge clk);
    if (clr)     m_count = 0;
    else if (t)  m_count = 0;
    else if (en) m_count = m_count + 1;
    if (t) m_ticks = (m_ticks + 1) % 65536;
`ifdef TICK_TRIM_EN
    if (trim_wr) m_trim = int'($signed(trim_val));
`endif
    @(negedge clk);
  endtask

  task automatic mark();
    cycle = 0;
    tick_cycles.delete();
  endtask

  initial begin
    int saved;
    en = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_count", count, 0);
    check("rst_ticks", ticks, 0);
    check("rst_tick",  tick,  1'b0);
    check("rst_half",  half,  1'b1);

    // Release and count freely: ticks land in cycles 20, 40, 60.
    @(negedge clk);
    rst_n = 1'b1;
    mark();
    repeat (60) cyc();
    check("free_n",     tick_cycles.size(), 3);
    check("free_t1",    nth_tick(0), 20);
    check("free_t2",    nth_tick(1), 40);
    check("free_t3",    nth_tick(2), 60);
    check("free_ticks", ticks, 3);

    // Hold at count 7 for 5 cycles: the next tick slips by 5 cycles.
    repeat (7) cyc();
    check("hold_start", count, 7);
    en = 1'b0;
    mark();
    repeat (5) cyc();
    check("hold_count", count, 7);
    en = 1'b1;
    repeat (13) cyc();
    check("hold_tick", nth_tick(0), 18);

    // Fast mode entered past its terminal: immediate tick, then every 5 cycles.
    repeat (12) cyc();
    check("fast_pre", count, 12);
    fast = 1'b1;
    #1 check("fast_now", tick, 1'b1);
    cyc();
    check("fast_wrap", count, 0);
    mark();
    repeat (15) cyc();
    check("fast_n",  tick_cycles.size(), 3);
    check("fast_t1", nth_tick(0), 5);
    check("fast_t3", nth_tick(2), 15);

    // clr on the terminal cycle suppresses the tick.
    fast = 1'b0;
    repeat (19) cyc();
    check("clr_pre", count, 19);
    saved = m_ticks;
    clr = 1'b1;
    #1 check("clr_tick", tick, 1'b0);
    cyc();
    clr = 1'b0;
    check("clr_count", count, 0);
    check("clr_ticks", ticks, saved);

`ifdef TICK_TRIM_EN
    // Trim -3 gives a 17-cycle period, +5 gives 25.
    mark();
    trim_val = 8'hFD;
    trim_wr  = 1'b1;
    cyc();
    trim_wr  = 1'b0;
    repeat (33) cyc();
    check("trim_m3_t1", nth_tick(0), 17);
    check("trim_m3_t2", nth_tick(1), 34);
    mark();
    trim_val = 8'd5;
    trim_wr  = 1'b1;
    cyc();
    trim_wr  = 1'b0;
    repeat (49) cyc();
    check("trim_p5_t1", nth_tick(0), 25);
    check("trim_p5_t2", nth_tick(1), 50);
`endif

    // Asynchronous reset between edges at count 14.
    repeat (14) cyc();
    check("arst_pre", count, 14);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_count", count, 0);
    check("arst_ticks", ticks, 0);
    check("arst_tick",  tick,  1'b0);
    check("arst_half",  half,  1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    mark();
    repeat (20) cyc();
    check("arst_first", nth_tick(0), 20);

    // Randomized enable, clear, mode and trim traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(99) < 85);
      clr  = ($urandom_range(99) < 3);
      if ($urandom_range(99) < 6) fast = ~fast;
`ifdef TICK_TRIM_EN
      trim_wr  = ($urandom_range(99) < 4);
      trim_val = 8'(int'($urandom_range(40)) - 20);
`endif
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
